exception_ctrl: RTL

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/exception_ctrl_prio_enc.sv | 20 ++
 rtl/exception_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: memory-address mux selectors, exception vectors,
// exception FSM states and cause codes.
package cpu_pkg;

    localparam logic [3:0] SEL_PC         = 4'b0000;
    localparam logic [3:0] SEL_ALU        = 4'b0001;
    localparam logic [3:0] SEL_EXC_OPCODE = 4'b0010;
    localparam logic [3:0] SEL_EXC_OVF    = 4'b0011;
    localparam logic [3:0] SEL_EXC_DIV0   = 4'b0100;

    // Byte addresses holding the handler address for each exception
    localparam logic [7:0] VEC_OPCODE = 8'd253;
    localparam logic [7:0] VEC_OVF    = 8'd254;
    localparam logic [7:0] VEC_DIV0   = 8'd255;

    localparam logic [1:0] CAUSE_OPCODE = 2'd0;
    localparam logic [1:0] CAUSE_OVF    = 2'd1;
    localparam logic [1:0] CAUSE_DIV0   = 2'd2;
    localparam logic [1:0] CAUSE_NONE   = 2'd3;

    typedef enum logic [2:0] {
        EXC_IDLE,
        EXC_SAVE,
        EXC_ADDR,
        EXC_WAIT,
        EXC_LOAD
    } exc_state_t;

    function automatic logic [3:0] cause_sel(input logic [1:0] c);
        case (c)
            CAUSE_OPCODE: cause_sel = SEL_EXC_OPCODE;
            CAUSE_OVF:    cause_sel = SEL_EXC_OVF;
            CAUSE_DIV0:   cause_sel = SEL_EXC_DIV0;
            default:      cause_sel = SEL_PC;
        endcase
    endfunction

endpackage

// File: rtl/exception_ctrl_prio_enc.sv
// Fixed-priority exception encoder: opcode > overflow > div0.
module exc_prio_enc
    import cpu_pkg::*;
(
    input  logic       exc_opcode,
    input  logic       exc_overflow,
    input  logic       exc_div0,
    output logic       vld,
    output logic [1:0] cause
);

    always_comb begin
        vld   = exc_opcode | exc_overflow | exc_div0;
        cause = CAUSE_NONE;
        if (exc_opcode)        cause = CAUSE_OPCODE;
        else if (exc_overflow) cause = CAUSE_OVF;
        else if (exc_div0)     cause = CAUSE_DIV0;
    end

endmodule

// File: rtl/exception_ctrl.sv
// Exception service sequencer: saves EPC, fetches the handler vector byte and loads PC.
// Define EXC_CAUSE_REG_EN to add the cause register write port (cause_we/cause_d).
module exception_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_sel,
    output logic        sel_own,
    output logic        epc_we,
    output logic [31:0] epc_d,
    output logic        pc_we,
    output logic [31:0] pc_d,
`ifdef EXC_CAUSE_REG_EN
    output logic        cause_we,
    output logic [31:0] cause_d,
`endif
    output logic        busy
);

    exc_state_t state;
    logic [1:0] cause_q;
    logic       det_vld;
    logic [1:0] det_cause;
    logic       unused_rdata;

    assign unused_rdata = ^mem_rdata[31:8];

    exc_prio_enc u_prio (
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_div0     (exc_div0),
        .vld          (det_vld),
        .cause        (det_cause)
    );

    // All outputs are registered, so each one is set on entry to the state that owns it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EXC_IDLE;
            cause_q  <= CAUSE_NONE;
            mem_sel  <= SEL_PC;
            sel_own  <= 1'b0;
            epc_we   <= 1'b0;
            epc_d    <= 32'd0;
            pc_we    <= 1'b0;
            pc_d     <= 32'd0;
            busy     <= 1'b0;
`ifdef EXC_CAUSE_REG_EN
            cause_we <= 1'b0;
            cause_d  <= 32'd0;
`endif
        end else begin
            case (state)
                EXC_IDLE: begin
                    if (det_vld) begin
                        state    <= EXC_SAVE;
                        cause_q  <= det_cause;
                        busy     <= 1'b1;
                        epc_we   <= 1'b1;
                        epc_d    <= pc - 32'd4;
`ifdef EXC_CAUSE_REG_EN
                        cause_we <= 1'b1;
                        cause_d  <= {30'd0, det_cause};
`endif
                    end
                end
                EXC_SAVE: begin
                    state    <= EXC_ADDR;
                    epc_we   <= 1'b0;
                    epc_d    <= 32'd0;
                    sel_own  <= 1'b1;
                    mem_sel  <= cause_sel(cause_q);
`ifdef EXC_CAUSE_REG_EN
                    cause_we <= 1'b0;
                    cause_d  <= 32'd0;
`endif
                end
                EXC_ADDR: state <= EXC_WAIT;
                EXC_WAIT: begin
                    // Read data for the vector address is valid during this cycle
                    state   <= EXC_LOAD;
                    sel_own <= 1'b0;
                    mem_sel <= SEL_PC;
                    pc_we   <= 1'b1;
                    pc_d    <= {24'd0, mem_rdata[7:0]};
                end
                EXC_LOAD: begin
                    state   <= EXC_IDLE;
                    cause_q <= CAUSE_NONE;
                    pc_we   <= 1'b0;
                    pc_d    <= 32'd0;
                    busy    <= 1'b0;
                end
                default: state <= EXC_IDLE;
            endcase
        end
    end

endmodule
